// File: rtl/dsd_mem_pkg.sv
// Shared definitions for the data-cache write buffer: line and address
// widths, default buffer depth and the controller state encoding.
package dsd_mem_pkg;

  localparam int LINE_W     = 128;
  localparam int LADDR_W    = 28;
  localparam int WBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } wbuf_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Write-buffer storage: a circular queue of line entries with valid bits,
// head/tail pointers, an occupancy count and a fully parallel
// line-address comparator. The matching entry's data is exported only
// when read forwarding is built in (macro DCACHE_WBUF_FORWARD_EN).
module wbuf_fifo
  import dsd_mem_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               update,
  input  logic               pop,
  input  logic [LADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0]  wr_data,
  input  logic [PTR_W-1:0]   update_idx,
  input  logic [LADDR_W-1:0] lookup_addr,
  output logic               hit,
  output logic [PTR_W-1:0]   hit_idx,
`ifdef DCACHE_WBUF_FORWARD_EN
  output logic [LINE_W-1:0]  hit_data,
`endif
  output logic [LADDR_W-1:0] head_addr,
  output logic [LINE_W-1:0]  head_data,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [LADDR_W-1:0] addr_r [DEPTH];
  logic [LINE_W-1:0]  data_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;
  logic [DEPTH-1:0]   hit_vec_s;
  logic [PTR_W-1:0]   hit_idx_s;

  // Entry storage, valid bits, wrapping pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
      valid_r <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        addr_r[tail_r]  <= wr_addr;
        data_r[tail_r]  <= wr_data;
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_ONE;
      end
      if (update) begin
        data_r[update_idx] <= wr_data;
      end
      if (pop) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Compare the lookup line address against every valid entry
  always_comb begin
    hit_vec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_s[i] = valid_r[i] && (addr_r[i] == lookup_addr);
    end
  end

  // Encode the matching slot; coalescing guarantees at most one match
  always_comb begin
    hit_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_idx_s = hit_idx_s | (hit_vec_s[i] ? PTR_W'(i) : PTR_W'(0));
    end
  end

  assign hit       = |hit_vec_s;
  assign hit_idx   = hit_idx_s;
`ifdef DCACHE_WBUF_FORWARD_EN
  assign hit_data  = data_r[hit_idx_s];
`endif
  assign head_addr = addr_r[head_r];
  assign head_data = data_r[head_r];
  assign count     = count_r;
  assign full      = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/dcache_write_buffer.sv
// Data-cache write buffer: absorbs line writes from the cache, coalesces
// writes to the same line, drains them to slow memory in FIFO order when
// the cache is quiet, and lets line reads bypass buffered writes.
// Macro DCACHE_WBUF_FORWARD_EN: serve reads that hit a buffered line
// straight from the buffer; otherwise drain until the line is no longer
// buffered and read it from memory.
module dcache_write_buffer
  import dsd_mem_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH
)(
  input  logic                     clk,
  input  logic                     proc_reset,
  input  logic                     c_read,
  input  logic                     c_write,
  input  logic [LADDR_W-1:0]       c_addr,
  input  logic [LINE_W-1:0]        c_wdata,
  output logic [LINE_W-1:0]        c_rdata,
  output logic                     c_ready,
  output logic                     m_read,
  output logic                     m_write,
  output logic [LADDR_W-1:0]       m_addr,
  output logic [LINE_W-1:0]        m_wdata,
  input  logic [LINE_W-1:0]        m_rdata,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   wbuf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_state_e        state_r, state_s;
  logic               c_ready_r, c_ready_s;
  logic [LINE_W-1:0]  c_rdata_r, c_rdata_s;
  logic               m_read_r, m_read_s;
  logic               m_write_r, m_write_s;
  logic [LADDR_W-1:0] m_addr_r, m_addr_s;
  logic [LINE_W-1:0]  m_wdata_r, m_wdata_s;
  logic               push_s, update_s, pop_s;
  logic               hit_s, full_s;
  logic [PTR_W-1:0]   hit_idx_s;
  logic [LADDR_W-1:0] head_addr_s;
  logic [LINE_W-1:0]  head_data_s;
  logic [CNT_W-1:0]   count_s;
`ifdef DCACHE_WBUF_FORWARD_EN
  logic [LINE_W-1:0]  hit_data_s;
`endif

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (proc_reset),
    .push        (push_s),
    .update      (update_s),
    .pop         (pop_s),
    .wr_addr     (c_addr),
    .wr_data     (c_wdata),
    .update_idx  (hit_idx_s),
    .lookup_addr (c_addr),
    .hit         (hit_s),
    .hit_idx     (hit_idx_s),
`ifdef DCACHE_WBUF_FORWARD_EN
    .hit_data    (hit_data_s),
`endif
    .head_addr   (head_addr_s),
    .head_data   (head_data_s),
    .count       (count_s),
    .full        (full_s)
  );

  // Next-state and next-output logic; requests are arbitrated only in IDLE
  always_comb begin
    state_s   = state_r;
    c_ready_s = 1'b0;
    c_rdata_s = c_rdata_r;
    m_read_s  = 1'b0;
    m_write_s = 1'b0;
    m_addr_s  = m_addr_r;
    m_wdata_s = m_wdata_r;
    push_s    = 1'b0;
    update_s  = 1'b0;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (c_read) begin
          if (hit_s) begin
`ifdef DCACHE_WBUF_FORWARD_EN
            c_rdata_s = hit_data_s;
            c_ready_s = 1'b1;
            state_s   = RESP;
`else
            m_write_s = 1'b1;
            m_addr_s  = head_addr_s;
            m_wdata_s = head_data_s;
            state_s   = DRAIN;
`endif
          end else begin
            m_read_s = 1'b1;
            m_addr_s = c_addr;
            state_s  = READ;
          end
        end else if (c_write) begin
          if (hit_s) begin
            update_s  = 1'b1;
            c_ready_s = 1'b1;
            state_s   = RESP;
          end else if (!full_s) begin
            push_s    = 1'b1;
            c_ready_s = 1'b1;
            state_s   = RESP;
          end else begin
            m_write_s = 1'b1;
            m_addr_s  = head_addr_s;
            m_wdata_s = head_data_s;
            state_s   = DRAIN;
          end
        end else if (count_s != '0) begin
          m_write_s = 1'b1;
          m_addr_s  = head_addr_s;
          m_wdata_s = head_data_s;
          state_s   = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          pop_s   = 1'b1;
          state_s = IDLE;
        end else begin
          m_write_s = 1'b1;
        end
      end
      READ: begin
        if (m_ready) begin
          c_rdata_s = m_rdata;
          c_ready_s = 1'b1;
          state_s   = RESP;
        end else begin
          m_read_s = 1'b1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered cache/memory-side outputs
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_r   <= IDLE;
      c_ready_r <= 1'b0;
      c_rdata_r <= '0;
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
      m_addr_r  <= '0;
      m_wdata_r <= '0;
    end else begin
      state_r   <= state_s;
      c_ready_r <= c_ready_s;
      c_rdata_r <= c_rdata_s;
      m_read_r  <= m_read_s;
      m_write_r <= m_write_s;
      m_addr_r  <= m_addr_s;
      m_wdata_r <= m_wdata_s;
    end
  end

  assign c_ready    = c_ready_r;
  assign c_rdata    = c_rdata_r;
  assign m_read     = m_read_r;
  assign m_write    = m_write_r;
  assign m_addr     = m_addr_r;
  assign m_wdata    = m_wdata_r;
  assign wbuf_count = count_s;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer (DEPTH=4). Expectations for
// read hits follow DCACHE_WBUF_FORWARD_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_dcache_write_buffer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         c_read, c_write;
  logic [27:0]  c_addr;
  logic [127:0] c_wdata, c_rdata;
  logic         c_ready;
  logic         m_read, m_write;
  logic [27:0]  m_addr;
  logic [127:0] m_wdata, m_rdata;
  logic         m_ready;
  logic [2:0]   wbuf_count;

  dcache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .wbuf_count(wbuf_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_op_t;

  typedef struct {
    bit           rd;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [2:0]   exp_cnt;
    logic [127:0] exp_rdata;
    bit           chk_lat;
    bit           settle;
  } vec_t;

  int checks = 0;
  int errors = 0;
  mem_op_t mem_log[$];
  mem_op_t exp_q[$];
  int stall = 0;
  int wait_cnt = 0;
  int cyc = 0;
  int both_err = 0;
  int cready_cnt = 0;
  int cready_cyc = 0;
  int last_rd_ready_cyc = -1;

  function automatic logic [127:0] pat(input logic [7:0] k);
    return {16{k}};
  endfunction

  function automatic logic [127:0] mem_data(input logic [27:0] a);
    return {4{4'hA, a}};
  endfunction

  function automatic vec_t mkv(input bit rd, input logic [27:0] a, input logic [127:0] d,
                               input logic [2:0] cnt, input logic [127:0] rdat,
                               input bit lat, input bit settle);
    vec_t v;
    v.rd = rd; v.addr = a; v.data = d; v.exp_cnt = cnt;
    v.exp_rdata = rdat; v.chk_lat = lat; v.settle = settle;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Slow memory: answers each request after `stall` extra cycles with a one-cycle m_ready
  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (c_ready) begin
        cready_cnt++;
        cready_cyc = cyc;
      end
      if (m_read && m_write) both_err++;
      if (m_ready) begin
        m_ready = 1'b0;
      end else if (m_read || m_write) begin
        if (wait_cnt >= stall) begin
          m_ready  = 1'b1;
          wait_cnt = 0;
          if (m_write) begin
            mem_log.push_back('{wr: 1'b1, addr: m_addr, data: m_wdata});
          end else begin
            m_rdata = mem_data(m_addr);
            mem_log.push_back('{wr: 1'b0, addr: m_addr, data: m_rdata});
            last_rd_ready_cyc = cyc;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic cache_req(input bit rd, input logic [27:0] a, input logic [127:0] d,
                           output logic [127:0] rdata, output int lat, output logic [2:0] cnt);
    c_read = rd; c_write = !rd; c_addr = a; c_wdata = d;
    lat = 0; rdata = '0; cnt = '0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (c_ready) begin
        lat = k; rdata = c_rdata; cnt = wbuf_count;
        break;
      end
    end
    check($sformatf("c_ready_seen addr %0h", a), 128'(lat != 0), 128'(1));
    @(posedge clk); #1;
    c_read = 1'b0; c_write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (wbuf_count == 3'd0 && !m_write && !m_read) begin
        done = 1'b1;
        break;
      end
    end
    check("drained_to_idle", 128'(done), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic compare_log(input string tag);
    check({tag, " log_len"}, 128'(mem_log.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mem_log.size(); i++) begin
      check($sformatf("%s op%0d is_write", tag, i), 128'(mem_log[i].wr), 128'(exp_q[i].wr));
      check($sformatf("%s op%0d addr", tag, i), 128'(mem_log[i].addr), 128'(exp_q[i].addr));
      check($sformatf("%s op%0d data", tag, i), mem_log[i].data, exp_q[i].data);
    end
    mem_log.delete();
    exp_q.delete();
  endtask

  vec_t vecs[11];
  logic [127:0] rd_s;
  int lat_s;
  logic [2:0] cnt_s;
  int base_s;

  initial begin
    // Table: back-to-back cache requests with expected count/rdata at c_ready
    vecs[0] = mkv(1'b0, 28'h100, pat(8'hAA), 3'd1, 128'd0, 1'b1, 1'b1);
    vecs[1] = mkv(1'b0, 28'h100, pat(8'hAA), 3'd1, 128'd0, 1'b1, 1'b0);
    vecs[2] = mkv(1'b0, 28'h100, pat(8'hBB), 3'd1, 128'd0, 1'b1, 1'b1);
    vecs[3] = mkv(1'b0, 28'h200, pat(8'hCC), 3'd1, 128'd0, 1'b1, 1'b0);
`ifdef DCACHE_WBUF_FORWARD_EN
    vecs[4] = mkv(1'b1, 28'h200, 128'd0, 3'd1, pat(8'hCC), 1'b1, 1'b1);
`else
    vecs[4] = mkv(1'b1, 28'h200, 128'd0, 3'd0, mem_data(28'h200), 1'b0, 1'b1);
`endif
    vecs[5] = mkv(1'b0, 28'h010, pat(8'h10), 3'd1, 128'd0, 1'b1, 1'b0);
    vecs[6] = mkv(1'b0, 28'h020, pat(8'h11), 3'd2, 128'd0, 1'b1, 1'b0);
    vecs[7] = mkv(1'b0, 28'h010, pat(8'h12), 3'd2, 128'd0, 1'b1, 1'b0);
    vecs[8] = mkv(1'b0, 28'h030, pat(8'h13), 3'd3, 128'd0, 1'b1, 1'b0);
    vecs[9] = mkv(1'b1, 28'h040, 128'd0, 3'd3, mem_data(28'h040), 1'b0, 1'b0);
`ifdef DCACHE_WBUF_FORWARD_EN
    vecs[10] = mkv(1'b1, 28'h020, 128'd0, 3'd3, pat(8'h11), 1'b1, 1'b1);
`else
    vecs[10] = mkv(1'b1, 28'h020, 128'd0, 3'd1, mem_data(28'h020), 1'b0, 1'b1);
`endif

    // Reset state
    proc_reset = 1'b1; c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst c_ready", 128'(c_ready), 128'(0));
    check("rst m_read", 128'(m_read), 128'(0));
    check("rst m_write", 128'(m_write), 128'(0));
    check("rst wbuf_count", 128'(wbuf_count), 128'(0));
    check("rst c_rdata", c_rdata, 128'd0);
    check("rst m_addr", 128'(m_addr), 128'(0));
    check("rst m_wdata", m_wdata, 128'd0);
    proc_reset = 1'b0;
    @(posedge clk); #1;

    // Phase 1: table vectors with zero memory stall
    stall = 0;
    for (int i = 0; i < 11; i++) begin
      cache_req(vecs[i].rd, vecs[i].addr, vecs[i].data, rd_s, lat_s, cnt_s);
      check($sformatf("v%0d wbuf_count", i), 128'(cnt_s), 128'(vecs[i].exp_cnt));
      if (vecs[i].rd) check($sformatf("v%0d c_rdata", i), rd_s, vecs[i].exp_rdata);
      if (vecs[i].chk_lat) check($sformatf("v%0d latency", i), 128'(lat_s), 128'(2));
      if (vecs[i].settle) wait_idle(400);
    end
    exp_q.push_back('{wr: 1'b1, addr: 28'h100, data: pat(8'hAA)});
    exp_q.push_back('{wr: 1'b1, addr: 28'h100, data: pat(8'hBB)});
    exp_q.push_back('{wr: 1'b1, addr: 28'h200, data: pat(8'hCC)});
`ifndef DCACHE_WBUF_FORWARD_EN
    exp_q.push_back('{wr: 1'b0, addr: 28'h200, data: mem_data(28'h200)});
`endif
    exp_q.push_back('{wr: 1'b0, addr: 28'h040, data: mem_data(28'h040)});
    exp_q.push_back('{wr: 1'b1, addr: 28'h010, data: pat(8'h12)});
    exp_q.push_back('{wr: 1'b1, addr: 28'h020, data: pat(8'h11)});
`ifndef DCACHE_WBUF_FORWARD_EN
    exp_q.push_back('{wr: 1'b0, addr: 28'h020, data: mem_data(28'h020)});
`endif
    exp_q.push_back('{wr: 1'b1, addr: 28'h030, data: pat(8'h13)});
    compare_log("table");

    // Phase 2: fill all entries, memory stalls 10 cycles, 5th write must wait for a drain
    stall = 10;
    for (int i = 0; i < 4; i++) begin
      cache_req(1'b0, 28'h400 + 28'(i), pat(8'hE0 + 8'(i)), rd_s, lat_s, cnt_s);
      check($sformatf("fill%0d wbuf_count", i), 128'(cnt_s), 128'(i + 1));
      check($sformatf("fill%0d latency", i), 128'(lat_s), 128'(2));
    end
    cache_req(1'b0, 28'h404, pat(8'hE4), rd_s, lat_s, cnt_s);
    check("full drains before c_ready", 128'(mem_log.size()), 128'(1));
    check("full write waited on stall", 128'(lat_s > 11), 128'(1));
    check("full wbuf_count", 128'(cnt_s), 128'(4));
    wait_idle(400);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{wr: 1'b1, addr: 28'h400 + 28'(i), data: pat(8'hE0 + 8'(i))});
    end
    compare_log("fifo_order");

    // Phase 3: unmatched read bypasses two buffered writes
    stall = 3;
    cache_req(1'b0, 28'h500, pat(8'h50), rd_s, lat_s, cnt_s);
    cache_req(1'b0, 28'h501, pat(8'h51), rd_s, lat_s, cnt_s);
    cache_req(1'b1, 28'h300, 128'd0, rd_s, lat_s, cnt_s);
    check("bypass c_rdata", rd_s, mem_data(28'h300));
    check("bypass wbuf_count", 128'(cnt_s), 128'(2));
    check("c_ready one cycle after m_ready", 128'(cready_cyc - last_rd_ready_cyc), 128'(1));
    wait_idle(400);
    exp_q.push_back('{wr: 1'b0, addr: 28'h300, data: mem_data(28'h300)});
    exp_q.push_back('{wr: 1'b1, addr: 28'h500, data: pat(8'h50)});
    exp_q.push_back('{wr: 1'b1, addr: 28'h501, data: pat(8'h51)});
    compare_log("bypass");

    // Phase 4: reset in the middle of a drain
    stall = 20;
    cache_req(1'b0, 28'h600, pat(8'h60), rd_s, lat_s, cnt_s);
    cache_req(1'b0, 28'h601, pat(8'h61), rd_s, lat_s, cnt_s);
    lat_s = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (m_write) begin
        lat_s = k;
        break;
      end
    end
    check("drain started", 128'(lat_s != 0), 128'(1));
    repeat (3) @(negedge clk);
    #2 proc_reset = 1'b1;
    #1;
    check("rst mid-drain m_write", 128'(m_write), 128'(0));
    check("rst mid-drain m_read", 128'(m_read), 128'(0));
    check("rst mid-drain wbuf_count", 128'(wbuf_count), 128'(0));
    base_s = cready_cnt;
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
    repeat (15) @(negedge clk);
    check("no c_ready after reset", 128'(cready_cnt - base_s), 128'(0));
    check("post-reset wbuf_count", 128'(wbuf_count), 128'(0));
    check("post-reset m_write", 128'(m_write), 128'(0));
    check("no memory write completed", 128'(mem_log.size()), 128'(0));
    mem_log.delete();

    check("m_read and m_write exclusive", 128'(both_err), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
